sc_screen_sequencer: RTL

//  Game-flow controller for the RoadFighter LED screen.

---
 rtl/sc_screen_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sc_screen_sequencer.sv
// Game-flow controller for the RoadFighter LED screen row MUX bank.
// Optional pause feature: define SC_SCREENSEQ_PAUSE_EN.
module sc_screen_sequencer #(
  parameter int SELECT_WIDTH    = 2,
  parameter int ROWS            = 7,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int GAMEOVER_TICKS  = 8,
  parameter int SCORE_WIDTH     = 8
) (
  input  logic                         SC_SCREENSEQ_CLOCK_50,
  input  logic                         SC_SCREENSEQ_RESET_InLow,
  input  logic                         SC_SCREENSEQ_START_InLow,
  input  logic                         SC_SCREENSEQ_TICK_InHigh,
  input  logic                         SC_SCREENSEQ_CRASH_InHigh,
  output logic [ROWS*SELECT_WIDTH-1:0] SC_SCREENSEQ_SELECT_OutBUS,
  output logic [2:0]                   SC_SCREENSEQ_STATE_OutBUS,
  output logic [SCORE_WIDTH-1:0]       SC_SCREENSEQ_SCORE_OutBUS,
  output logic                         SC_SCREENSEQ_RUN_OutHigh
);

  localparam int SEL_W = ROWS * SELECT_WIDTH;
  localparam int MAX_T = (COUNTDOWN_TICKS > GAMEOVER_TICKS) ?
                         COUNTDOWN_TICKS : GAMEOVER_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_TICKS - 1);
  localparam logic [CNT_W-1:0] GO_LAST = CNT_W'(GAMEOVER_TICKS - 1);

  localparam logic [SELECT_WIDTH-1:0] ONE_F = SELECT_WIDTH'(1);
  localparam logic [SELECT_WIDTH-1:0] ROAD  = SELECT_WIDTH'(2);
  localparam logic [SEL_W-1:0]        SEL_ONES = {ROWS{ONE_F}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    GAMEOVER  = 3'd3,
    PAUSE     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   run_q, run_d;
  logic                   start_q;
  logic                   press, tick, crash;

  assign press = start_q & ~SC_SCREENSEQ_START_InLow;
  assign tick  = SC_SCREENSEQ_TICK_InHigh;
  assign crash = SC_SCREENSEQ_CRASH_InHigh;

  // State, counters, outputs and button history registers
  always_ff @(posedge SC_SCREENSEQ_CLOCK_50 or
              negedge SC_SCREENSEQ_RESET_InLow) begin
    if (!SC_SCREENSEQ_RESET_InLow) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      score_q <= '0;
      run_q   <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      score_q <= score_d;
      run_q   <= run_d;
      start_q <= SC_SCREENSEQ_START_InLow;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (press) begin
          state_d = COUNTDOWN;
          cnt_d   = '0;
          score_d = '0;
          sel_d   = SEL_ONES;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (cnt_q == CD_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            sel_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (crash) begin
          state_d = GAMEOVER;
          sel_d   = SEL_ONES;
          cnt_d   = '0;
`ifdef SC_SCREENSEQ_PAUSE_EN
        end else if (press) begin
          state_d = PAUSE;
`endif
        end else if (tick) begin
          sel_d = {sel_q[SEL_W-SELECT_WIDTH-1:0], ROAD};
          if (score_q != '1)
            score_d = score_q + SCORE_WIDTH'(1);
        end
      end
      GAMEOVER: begin
        if (tick) begin
          if (cnt_q == GO_LAST) begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
          end else begin
            sel_d = (sel_q == '0) ? SEL_ONES : '0;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SC_SCREENSEQ_PAUSE_EN
      PAUSE: begin
        if (crash) begin
          state_d = GAMEOVER;
          sel_d   = SEL_ONES;
          cnt_d   = '0;
        end else if (press) begin
          state_d = RUN;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
    run_d = (state_d == RUN);
  end

  assign SC_SCREENSEQ_SELECT_OutBUS = sel_q;
  assign SC_SCREENSEQ_STATE_OutBUS  = state_q;
  assign SC_SCREENSEQ_SCORE_OutBUS  = score_q;
  assign SC_SCREENSEQ_RUN_OutHigh   = run_q;

endmodule
